// File: rtl/kuuga_cache_pkg.sv
// Shared AXI encodings and controller state type for the direct-mapped
// cache's memory-side master.
package kuuga_cache_pkg;

    typedef enum logic [1:0] {
        AXI_BURST_FIXED = 2'b00,
        AXI_BURST_INCR  = 2'b01,
        AXI_BURST_WRAP  = 2'b10
    } axi_burst_e;

    typedef enum logic [1:0] {
        AXI_RESP_OKAY   = 2'b00,
        AXI_RESP_EXOKAY = 2'b01,
        AXI_RESP_SLVERR = 2'b10,
        AXI_RESP_DECERR = 2'b11
    } axi_resp_e;

    localparam logic [2:0] AXI_SIZE_4B = 3'b010;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD_ADDR,
        ST_RD_DATA,
        ST_WR_BURST,
        ST_WR_RESP,
        ST_DONE
    } dm_axi_state_e;

endpackage

// File: rtl/dm_cache_line_buf.sv
// One cache line of 32-bit words: assembled beat by beat on fills,
// loaded whole and read out beat by beat on writebacks.
module dm_cache_line_buf #(
    parameter int LINE_WORDS = 4,
    localparam int IDX_W = $clog2(LINE_WORDS)
) (
    input  logic                      clk,
    input  logic                      load_en,
    input  logic [32*LINE_WORDS-1:0]  load_line,
    input  logic                      wr_en,
    input  logic [IDX_W-1:0]          idx,
    input  logic [31:0]               wr_word,
    output logic [31:0]               rd_word,
    output logic [32*LINE_WORDS-1:0]  line
);

    logic [31:0] words [LINE_WORDS];

    // NOTE: line storage has no reset; every word is written before it is used.
    always_ff @(posedge clk) begin
        if (load_en) begin
            for (int i = 0; i < LINE_WORDS; i++) begin
                words[i] <= load_line[32*i +: 32];
            end
        end else if (wr_en) begin
            words[idx] <= wr_word;
        end
    end

    assign rd_word = words[idx];

    always_comb begin
        for (int i = 0; i < LINE_WORDS; i++) begin
            line[32*i +: 32] = words[i];
        end
    end

endmodule

// File: rtl/dm_cache_axi_master.sv
// AXI4 master for the direct-mapped cache: one line fill or one dirty-line
// writeback per request, issued as a single INCR burst.
module dm_cache_axi_master
    import kuuga_cache_pkg::*;
#(
    parameter int LINE_WORDS = 4,
    parameter int ADDR_WIDTH = 32,
    parameter int AXI_ID     = 0
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic                      req_write,
    input  logic [ADDR_WIDTH-1:0]     req_addr,
    input  logic [32*LINE_WORDS-1:0]  req_wdata,
    output logic                      resp_valid,
    output logic [32*LINE_WORDS-1:0]  resp_rdata,
    output logic                      resp_error,
    output logic [3:0]                m_axi_arid,
    output logic [ADDR_WIDTH-1:0]     m_axi_araddr,
    output logic [7:0]                m_axi_arlen,
    output logic [2:0]                m_axi_arsize,
    output logic [1:0]                m_axi_arburst,
    output logic                      m_axi_arvalid,
    input  logic                      m_axi_arready,
    input  logic [3:0]                m_axi_rid,
    input  logic [31:0]               m_axi_rdata,
    input  logic [1:0]                m_axi_rresp,
    input  logic                      m_axi_rlast,
    input  logic                      m_axi_rvalid,
    output logic                      m_axi_rready,
    output logic [3:0]                m_axi_awid,
    output logic [ADDR_WIDTH-1:0]     m_axi_awaddr,
    output logic [7:0]                m_axi_awlen,
    output logic [2:0]                m_axi_awsize,
    output logic [1:0]                m_axi_awburst,
    output logic                      m_axi_awvalid,
    input  logic                      m_axi_awready,
    output logic [31:0]               m_axi_wdata,
    output logic [3:0]                m_axi_wstrb,
    output logic                      m_axi_wlast,
    output logic                      m_axi_wvalid,
    input  logic                      m_axi_wready,
    input  logic [3:0]                m_axi_bid,
    input  logic [1:0]                m_axi_bresp,
    input  logic                      m_axi_bvalid,
    output logic                      m_axi_bready
);

    localparam int IDX_W = $clog2(LINE_WORDS);
    localparam int OFF_W = $clog2(LINE_WORDS * 4);
    localparam logic [IDX_W-1:0] LAST_BEAT = IDX_W'(LINE_WORDS - 1);

    dm_axi_state_e state_q, state_d;

    logic [ADDR_WIDTH-1:0]     addr_q;
    logic [IDX_W-1:0]          beat_q;
    logic                      err_q;
    logic                      aw_done_q;
    logic                      w_done_q;
    logic                      idle_q;
    logic [32*LINE_WORDS-1:0]  rdata_q;
    logic [32*LINE_WORDS-1:0]  buf_line;
    logic [32*LINE_WORDS-1:0]  fill_line;
    logic [31:0]               buf_rd_word;

    logic accept, last_beat, r_hs, aw_hs, w_hs, b_hs, aw_fin, w_fin;
    logic unused_ok;

    // Handshakes are decoded from state so they never loop through the outputs.
    assign accept    = req_valid & idle_q;
    assign last_beat = (beat_q == LAST_BEAT);
    assign r_hs      = (state_q == ST_RD_DATA)  & m_axi_rvalid;
    assign aw_hs     = (state_q == ST_WR_BURST) & ~aw_done_q & m_axi_awready;
    assign w_hs      = (state_q == ST_WR_BURST) & ~w_done_q  & m_axi_wready;
    assign b_hs      = (state_q == ST_WR_RESP)  & m_axi_bvalid;
    assign aw_fin    = aw_done_q | aw_hs;
    assign w_fin     = w_done_q  | (w_hs & last_beat);

    assign unused_ok = ^{m_axi_rid, m_axi_bid, req_addr[OFF_W-1:0]};

    dm_cache_line_buf #(.LINE_WORDS(LINE_WORDS)) u_line_buf (
        .clk       (clk),
        .load_en   (accept & req_write),
        .load_line (req_wdata),
        .wr_en     (r_hs),
        .idx       (beat_q),
        .wr_word   (m_axi_rdata),
        .rd_word   (buf_rd_word),
        .line      (buf_line)
    );

    // The final beat is merged straight from the bus so the line is complete in DONE.
    always_comb begin
        fill_line = buf_line;
        fill_line[32*(LINE_WORDS-1) +: 32] = m_axi_rdata;
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    // NOTE: every output of this block gets a default first, so no latches form.
    always_comb begin
        state_d       = state_q;
        m_axi_arvalid = 1'b0;
        m_axi_rready  = 1'b0;
        m_axi_awvalid = 1'b0;
        m_axi_wvalid  = 1'b0;
        m_axi_bready  = 1'b0;
        resp_valid    = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (accept) state_d = req_write ? ST_WR_BURST : ST_RD_ADDR;
            end
            ST_RD_ADDR: begin
                m_axi_arvalid = 1'b1;
                if (m_axi_arready) state_d = ST_RD_DATA;
            end
            ST_RD_DATA: begin
                m_axi_rready = 1'b1;
                if (m_axi_rvalid && last_beat) state_d = ST_DONE;
            end
            ST_WR_BURST: begin
                m_axi_awvalid = ~aw_done_q;
                m_axi_wvalid  = ~w_done_q;
                if (aw_fin && w_fin) state_d = ST_WR_RESP;
            end
            ST_WR_RESP: begin
                m_axi_bready = 1'b1;
                if (m_axi_bvalid) state_d = ST_DONE;
            end
            ST_DONE: begin
                resp_valid = 1'b1;
                state_d    = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idle_q    <= 1'b0;
            addr_q    <= '0;
            beat_q    <= '0;
            err_q     <= 1'b0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            rdata_q   <= '0;
        end else begin
            idle_q <= (state_d == ST_IDLE);
            if (accept) begin
                addr_q    <= {req_addr[ADDR_WIDTH-1:OFF_W], {OFF_W{1'b0}}};
                beat_q    <= '0;
                err_q     <= 1'b0;
                aw_done_q <= 1'b0;
                w_done_q  <= 1'b0;
            end
            if (r_hs) begin
                beat_q <= beat_q + 1'b1;
                // A misplaced or missing RLAST is reported like a bad RRESP.
                if ((m_axi_rresp != AXI_RESP_OKAY) || (m_axi_rlast != last_beat)) err_q <= 1'b1;
                if (last_beat) rdata_q <= fill_line;
            end
            if (aw_hs) aw_done_q <= 1'b1;
            if (w_hs) begin
                beat_q <= beat_q + 1'b1;
                if (last_beat) w_done_q <= 1'b1;
            end
            if (b_hs && (m_axi_bresp != AXI_RESP_OKAY)) err_q <= 1'b1;
        end
    end

    assign req_ready  = idle_q;
    assign resp_rdata = rdata_q;
    assign resp_error = (state_q == ST_DONE) & err_q;

    assign m_axi_arid    = 4'(AXI_ID);
    assign m_axi_araddr  = addr_q;
    assign m_axi_arlen   = 8'(LINE_WORDS - 1);
    assign m_axi_arsize  = AXI_SIZE_4B;
    assign m_axi_arburst = AXI_BURST_INCR;

    assign m_axi_awid    = 4'(AXI_ID);
    assign m_axi_awaddr  = addr_q;
    assign m_axi_awlen   = 8'(LINE_WORDS - 1);
    assign m_axi_awsize  = AXI_SIZE_4B;
    assign m_axi_awburst = AXI_BURST_INCR;

    assign m_axi_wdata   = buf_rd_word;
    assign m_axi_wstrb   = 4'hF;
    assign m_axi_wlast   = last_beat;

endmodule

// File: tb/tb_dm_cache_axi_master.sv
// Directed bench for dm_cache_axi_master against a small AXI slave memory
// with configurable AW delay, backpressure and error injection.
module tb_dm_cache_axi_master;
    import kuuga_cache_pkg::*;

    localparam int LW = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         req_valid = 1'b0, req_write = 1'b0;
    logic [31:0]  req_addr = '0;
    logic [127:0] req_wdata = '0;
    logic         req_ready, resp_valid, resp_error;
    logic [127:0] resp_rdata;
    logic [3:0]   arid, awid, rid, bid;
    logic [31:0]  araddr, awaddr, rdata, wdata;
    logic [7:0]   arlen, awlen;
    logic [2:0]   arsize, awsize;
    logic [1:0]   arburst, awburst, rresp, bresp;
    logic         arvalid, arready, rlast, rvalid, rready;
    logic         awvalid, awready, wlast, wvalid, wready, bvalid, bready;
    logic [3:0]   wstrb;

    always #5 clk = ~clk;

    dm_cache_axi_master #(.LINE_WORDS(LW), .ADDR_WIDTH(32), .AXI_ID(0)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_error(resp_error),
        .m_axi_arid(arid), .m_axi_araddr(araddr), .m_axi_arlen(arlen),
        .m_axi_arsize(arsize), .m_axi_arburst(arburst),
        .m_axi_arvalid(arvalid), .m_axi_arready(arready),
        .m_axi_rid(rid), .m_axi_rdata(rdata), .m_axi_rresp(rresp),
        .m_axi_rlast(rlast), .m_axi_rvalid(rvalid), .m_axi_rready(rready),
        .m_axi_awid(awid), .m_axi_awaddr(awaddr), .m_axi_awlen(awlen),
        .m_axi_awsize(awsize), .m_axi_awburst(awburst),
        .m_axi_awvalid(awvalid), .m_axi_awready(awready),
        .m_axi_wdata(wdata), .m_axi_wstrb(wstrb), .m_axi_wlast(wlast),
        .m_axi_wvalid(wvalid), .m_axi_wready(wready),
        .m_axi_bid(bid), .m_axi_bresp(bresp), .m_axi_bvalid(bvalid), .m_axi_bready(bready)
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // ---------------- slave memory model ----------------
    logic [31:0] mem [1024];
    logic [7:0]  aw_delay   = 8'd0;
    bit          bp         = 1'b0;
    logic [7:0]  err_beat   = 8'hFF;
    logic [7:0]  rlast_beat = 8'(LW - 1);
    logic [1:0]  bresp_cfg  = 2'b00;

    function automatic bit coin();
        return bp ? bit'($urandom_range(0, 1)) : 1'b1;
    endfunction

    logic       r_active, rvalid_q;
    logic [9:0] r_base;
    logic [7:0] r_cnt;

    assign arready = 1'b1;
    assign rvalid  = rvalid_q;
    assign rdata   = mem[r_base + r_cnt[1:0]];
    assign rresp   = (r_cnt == err_beat) ? 2'b10 : 2'b00;
    assign rlast   = (r_cnt == rlast_beat);
    assign rid     = 4'h0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            r_active <= 1'b0;
            rvalid_q <= 1'b0;
            r_cnt    <= '0;
            r_base   <= '0;
        end else if (!r_active) begin
            if (arvalid && arready) begin
                r_active <= 1'b1;
                r_base   <= araddr[11:2];
                r_cnt    <= '0;
                rvalid_q <= coin();
            end
        end else if (rvalid_q && rready) begin
            if (r_cnt == 8'(LW - 1)) begin
                r_active <= 1'b0;
                rvalid_q <= 1'b0;
            end else begin
                r_cnt    <= r_cnt + 8'd1;
                rvalid_q <= coin();
            end
        end else if (!rvalid_q) begin
            rvalid_q <= coin();
        end
    end

    logic [7:0]  aw_wait, w_cnt;
    logic        aw_got, w_got, bvalid_q, wready_q;
    logic [9:0]  aw_base;
    logic [31:0] wbuf [LW];

    assign awready = awvalid && (aw_wait >= aw_delay);
    assign wready  = wready_q;
    assign bvalid  = bvalid_q;
    assign bresp   = bresp_cfg;
    assign bid     = 4'h0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            aw_wait  <= '0;
            w_cnt    <= '0;
            aw_got   <= 1'b0;
            w_got    <= 1'b0;
            bvalid_q <= 1'b0;
            wready_q <= 1'b0;
            aw_base  <= '0;
        end else begin
            wready_q <= coin();
            if (awvalid && !awready) aw_wait <= aw_wait + 8'd1;
            if (awvalid && awready) begin
                aw_got  <= 1'b1;
                aw_base <= awaddr[11:2];
                aw_wait <= '0;
            end
            if (wvalid && wready) begin
                wbuf[w_cnt[1:0]] <= wdata;
                w_cnt <= w_cnt + 8'd1;
                if (wlast) w_got <= 1'b1;
            end
            if (aw_got && w_got && !bvalid_q) begin
                for (int i = 0; i < LW; i++) mem[aw_base + 10'(i)] <= wbuf[i];
                bvalid_q <= 1'b1;
            end
            if (bvalid_q && bready) begin
                bvalid_q <= 1'b0;
                aw_got   <= 1'b0;
                w_got    <= 1'b0;
                w_cnt    <= '0;
            end
        end
    end

    // ---------------- protocol monitor ----------------
    int          cyc = 0;
    int          drop_err = 0, overlap_err = 0, wlast_bad = 0, resp_cnt = 0;
    int          aw_hs_cyc = 0, wlast_cyc = 0, b_cyc = 0, resp_cyc = 0;
    logic [1:0]  w_idx;
    logic [31:0] mon_araddr = '0, mon_awaddr = '0;
    logic [7:0]  mon_arlen = '0, mon_awlen = '0;
    logic [2:0]  mon_arsize = '0;
    logic [1:0]  mon_arburst = '0;
    logic        p_arv, p_arr, p_awv, p_awr, p_wv, p_wr;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            {p_arv, p_arr, p_awv, p_awr, p_wv, p_wr} <= '0;
            w_idx <= '0;
        end else begin
            {p_arv, p_arr, p_awv, p_awr, p_wv, p_wr} <= {arvalid, arready, awvalid, awready, wvalid, wready};
            if ((p_arv && !p_arr && !arvalid) || (p_awv && !p_awr && !awvalid) ||
                (p_wv && !p_wr && !wvalid)) drop_err <= drop_err + 1;
            if ((arvalid && (awvalid || wvalid || bready)) || (arvalid && r_active) ||
                ((awvalid || wvalid) && (r_active || rready))) overlap_err <= overlap_err + 1;
            if (arvalid && arready) begin
                mon_araddr  <= araddr;
                mon_arlen   <= arlen;
                mon_arsize  <= arsize;
                mon_arburst <= arburst;
            end
            if (awvalid && awready) begin
                mon_awaddr <= awaddr;
                mon_awlen  <= awlen;
                aw_hs_cyc  <= cyc;
            end
            if (wvalid && wready) begin
                if (wlast != (w_idx == 2'd3)) wlast_bad <= wlast_bad + 1;
                if (wlast) wlast_cyc <= cyc;
                w_idx <= w_idx + 2'd1;
            end
            if (bvalid && bready) b_cyc <= cyc;
            if (resp_valid) begin
                resp_cnt <= resp_cnt + 1;
                resp_cyc <= cyc;
            end
        end
    end

    // ---------------- request driver ----------------
    logic rdy_at_resp;

    task automatic do_req(input bit wr, input logic [31:0] addr, input logic [127:0] wd,
                          output logic [127:0] rd, output logic err, output int lat);
        int wait_cnt;
        @(negedge clk);
        req_valid = 1'b1;
        req_write = wr;
        req_addr  = addr;
        req_wdata = wd;
        wait_cnt  = 0;
        while (!req_ready && wait_cnt < 100) begin
            @(negedge clk);
            wait_cnt++;
        end
        check("req_accepted", req_ready, 1'b1);
        @(posedge clk);
        #1 req_valid = 1'b0;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!resp_valid && lat < 500);
        check("resp_seen", resp_valid, 1'b1);
        rd = resp_rdata;
        err = resp_error;
        rdy_at_resp = req_ready;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    logic [127:0] rd, wd;
    logic         err;
    int           lat, resp_before;
    logic [31:0]  a;

    initial begin
        // Reset state.
        repeat (2) @(negedge clk);
        check("rst_ctrl", {req_ready, resp_valid, resp_error, arvalid, rready, awvalid, wvalid, bready}, 8'h00);
        check("rst_rdata", resp_rdata, 128'h0);
        rst = 1'b0;
        @(negedge clk);
        check("ready_after_rst", req_ready, 1'b1);

        // Fill with a zero-wait slave, line preloaded by a writeback.
        do_req(1'b1, 32'h100, 128'h00000044_00000033_00000022_00000011, rd, err, lat);
        do_req(1'b0, 32'h104, '0, rd, err, lat);
        check("fill_araddr", mon_araddr, 32'h100);
        check("fill_arlen", mon_arlen, 8'd3);
        check("fill_arsize_burst", {mon_arsize, mon_arburst}, {3'b010, 2'b01});
        check("fill_latency", lat, 6);
        check("fill_rdata", rd, 128'h00000044_00000033_00000022_00000011);
        check("fill_error", err, 1'b0);
        check("ready_in_done", rdy_at_resp, 1'b0);
        @(negedge clk);
        check("resp_one_cycle", resp_valid, 1'b0);
        check("ready_after_done", req_ready, 1'b1);

        // Writeback with AW held off for five cycles.
        aw_delay = 8'd5;
        resp_before = resp_cnt;
        wd = {32'hD, 32'hC, 32'hB, 32'hA};
        do_req(1'b1, 32'h200, wd, rd, err, lat);
        repeat (3) @(negedge clk);
        check("wb_error", err, 1'b0);
        check("wb_awaddr_len", {mon_awaddr, mon_awlen}, {32'h200, 8'd3});
        check("wb_mem", {mem[10'h83], mem[10'h82], mem[10'h81], mem[10'h80]}, wd);
        check("wb_w_before_aw", wlast_cyc < aw_hs_cyc, 1'b1);
        check("wb_resp_after_b", resp_cyc, b_cyc + 1);
        check("wb_resp_pulses", resp_cnt - resp_before, 1);
        aw_delay = 8'd0;

        // SLVERR on beat 2: all beats still consumed and delivered.
        do_req(1'b1, 32'h300, 128'hCAFE0004_CAFE0003_CAFE0002_CAFE0001, rd, err, lat);
        err_beat = 8'd2;
        do_req(1'b0, 32'h308, '0, rd, err, lat);
        check("slverr_flag", err, 1'b1);
        check("slverr_rdata", rd, 128'hCAFE0004_CAFE0003_CAFE0002_CAFE0001);
        check("slverr_burst_done", r_active, 1'b0);
        err_beat = 8'hFF;

        // Early RLAST on beat 1.
        rlast_beat = 8'd1;
        do_req(1'b0, 32'h300, '0, rd, err, lat);
        check("early_rlast_flag", err, 1'b1);
        rlast_beat = 8'(LW - 1);
        do_req(1'b0, 32'h100, '0, rd, err, lat);
        check("err_cleared", err, 1'b0);

        // Write response error.
        bresp_cfg = 2'b10;
        do_req(1'b1, 32'h400, 128'h1, rd, err, lat);
        check("bresp_err_flag", err, 1'b1);
        bresp_cfg = 2'b00;

        // Alternating writebacks and fills under random backpressure.
        bp = 1'b1;
        for (int i = 0; i < 100; i++) begin
            a  = 32'($urandom_range(0, 255)) * 32'd16;
            wd = {$urandom, $urandom, $urandom, $urandom};
            aw_delay = 8'($urandom_range(0, 3));
            do_req(1'b1, a, wd, rd, err, lat);
            check("rnd_wb_err", err, 1'b0);
            do_req(1'b0, a | 32'($urandom_range(0, 15)), '0, rd, err, lat);
            check("rnd_fill_rdata", rd, wd);
            check("rnd_fill_err", err, 1'b0);
        end
        bp = 1'b0;
        aw_delay = 8'd0;

        // Reset pulsed during the second read beat.
        @(negedge clk);
        req_valid = 1'b1;
        req_write = 1'b0;
        req_addr  = 32'h100;
        @(posedge clk);
        #1 req_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_mid_beat1", {rvalid, rready, r_cnt}, {2'b11, 8'd1});
        resp_before = resp_cnt;
        rst = 1'b1;
        #1;
        check("rst_mid_valids", {arvalid, rready, awvalid, wvalid, bready, resp_valid, req_ready}, 7'h00);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_mid_ready", req_ready, 1'b1);
        repeat (5) @(negedge clk);
        check("rst_mid_no_resp", resp_cnt - resp_before, 0);
        do_req(1'b0, 32'h100, '0, rd, err, lat);
        check("rst_recover_rdata", rd, 128'h00000044_00000033_00000022_00000011);

        // Whole-run protocol invariants.
        check("no_valid_dropped", drop_err, 0);
        check("one_burst_in_flight", overlap_err, 0);
        check("wlast_placement", wlast_bad, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
